// File: rtl/alu_rr_arbiter_if.sv
// Requester-side bundle for alu_rr_arbiter: request handshake, operands and
// the shared one-hot result strobe.
interface alu_rr_arbiter_if #(
  parameter int WIDTH   = 6,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined add/sub ALU among NUM_REQ requesters.
// Optional per-requester grant and busy counters: define ALU_ARB_STATS_EN.
module alu_rr_arbiter #(
  parameter int WIDTH   = 6,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_rr_arbiter_if.slave  bus,
  output logic [1:0]       alu_op_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic             alu_in_valid_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_out_valid_i,
  output logic             err_o
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0] grant_cnt_o,
  output logic [15:0]           busy_cnt_o
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] win_s;
  logic [IDW:0]   idx_s;
  logic           found_s;
  logic           hit_s;
  logic           hs_s;
  logic           err_q;
  logic           resp_ok_s;
  logic [LATENCY-1:0] tag_v_q;
  logic [IDW-1:0]     tag_id_q [LATENCY];

  // Rotating first-set search starting at rr_ptr_q.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s   = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      idx_s   = (idx_s >= (IDW+1)'(NUM_REQ)) ? (idx_s - (IDW+1)'(NUM_REQ)) : idx_s;
      hit_s   = bus.req_valid[idx_s[IDW-1:0]];
      win_s   = (!found_s && hit_s) ? idx_s[IDW-1:0] : win_s;
      found_s = found_s | hit_s;
    end
  end

  assign hs_s = found_s & ~rst;

  // Grant and ALU drive from the winning requester's slice.
  always_comb begin
    bus.req_ready  = '0;
    alu_op_o       = 2'b00;
    alu_a_o        = '0;
    alu_b_o        = '0;
    alu_in_valid_o = 1'b0;
    if (hs_s) begin
      bus.req_ready  = NUM_REQ'(1) << win_s;
      alu_op_o       = bus.req_op[2*win_s +: 2];
      alu_a_o        = bus.req_a[WIDTH*win_s +: WIDTH];
      alu_b_o        = bus.req_b[WIDTH*win_s +: WIDTH];
      alu_in_valid_o = 1'b1;
    end else begin
      alu_in_valid_o = 1'b0;
    end
  end

  // Pointer advances past the winner only when a handshake happens.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs_s) begin
      rr_ptr_d = (win_s == IDW'(NUM_REQ-1)) ? '0 : (win_s + IDW'(1));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer, tag pipeline and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      tag_v_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_v_q[0]  <= hs_s;
      tag_id_q[0] <= win_s;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
      if (alu_out_valid_i != tag_v_q[LATENCY-1]) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

  // A result is routed only when the ALU and the tag pipeline agree.
  assign resp_ok_s = alu_out_valid_i & tag_v_q[LATENCY-1] & ~rst;

  always_comb begin
    bus.resp_valid = '0;
    bus.resp_data  = '0;
    if (resp_ok_s) begin
      bus.resp_valid = NUM_REQ'(1) << tag_id_q[LATENCY-1];
      bus.resp_data  = alu_out_i;
    end else begin
      bus.resp_data  = '0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [15:0] busy_cnt_q;

  // Saturating usage counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= 16'h0000;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= 16'h0000;
    end else begin
      if (alu_in_valid_o && (busy_cnt_q != 16'hFFFF)) begin
        busy_cnt_q <= busy_cnt_q + 16'h0001;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs_s && (win_s == IDW'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'h0001;
        end
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt_o[16*i +: 16] = grant_cnt_q[i];
  end

  assign busy_cnt_o = busy_cnt_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter with a behavioural 2-cycle add/sub ALU.
module tb_alu_rr_arbiter;
  localparam int W = 6;
  localparam int N = 4;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_rr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  logic [1:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic         alu_in_valid, alu_out_valid, err;
  logic         force_ov;
`ifdef ALU_ARB_STATS_EN
  logic [16*N-1:0] grant_cnt;
  logic [15:0]     busy_cnt;
`endif

  alu_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .LATENCY(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .alu_op_o        (alu_op),
    .alu_a_o         (alu_a),
    .alu_b_o         (alu_b),
    .alu_in_valid_o  (alu_in_valid),
    .alu_out_i       (alu_out),
    .alu_out_valid_i (alu_out_valid),
    .err_o           (err)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt_o     (grant_cnt),
    .busy_cnt_o      (busy_cnt)
`endif
  );

  // Behavioural alu2: two register stages, nop returns 0 with valid.
  logic [W-1:0] r1, r2;
  logic         v1, v2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= '0; r2 <= '0; v1 <= 1'b0; v2 <= 1'b0;
    end else begin
      v1 <= alu_in_valid;
      r1 <= (alu_op == OP_ADD) ? alu_a + alu_b : (alu_op == OP_SUB) ? alu_a - alu_b : '0;
      v2 <= v1;
      r2 <= r1;
    end
  end
  assign alu_out       = r2;
  assign alu_out_valid = v2 | force_ov;

  int checks = 0;
  int fails  = 0;
  logic [N+W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got valid=%b data=%0d, expected none", bus.resp_valid, bus.resp_data);
      end else begin
        logic [N+W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.resp_valid, bus.resp_data} !== e) begin
          fails++;
          $display("FAIL resp: got valid=%b data=%0d, expected valid=%b data=%0d",
                   bus.resp_valid, bus.resp_data, e[N+W-1:W], e[W-1:0]);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op[2*i +: 2] = op;
    bus.req_a[W*i +: W]  = a;
    bus.req_b[W*i +: W]  = b;
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] er, input logic [W-1:0] ed);
    bus.req_valid = v;
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("alu_in_valid", 32'(alu_in_valid), 32'((|v) && !rst));
    if (er != '0) exp_q.push_back({er, ed});
    @(posedge clk); #1;
  endtask

  task automatic idle_quiet();
    bus.req_valid = '0;
    @(negedge clk);
    chk("resp_quiet", 32'(bus.resp_valid), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    force_ov = 1'b0;
    repeat (2) @(posedge clk); #1;
    // reset state: requests ignored while rst is high
    bus.req_valid = 4'hF;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_in_valid", 32'(alu_in_valid), 32'h0);
    chk("rst_resp", 32'(bus.resp_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single add, sub with wrap, add overflow
    set_req(1, OP_ADD, 6'd5, 6'd3);   cycle(4'b0010, 4'b0010, 6'd8);
    set_req(0, OP_SUB, 6'd3, 6'd5);   cycle(4'b0001, 4'b0001, 6'h3E);
    set_req(0, OP_ADD, 6'd63, 6'd1);  cycle(4'b0001, 4'b0001, 6'd0);
    repeat (3) cycle(4'b0000, 4'b0000, 6'd0);
    chk("err_after_arith", 32'(err), 32'h0);

    // fairness from a fresh pointer
    rst = 1'b1; cycle(4'b0000, 4'b0000, 6'd0); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, OP_ADD, 6'(i + 1), 6'd10);
    for (int k = 0; k < 8; k++) cycle(4'hF, 4'(1 << (k % 4)), 6'(11 + (k % 4)));
    repeat (3) cycle(4'b0000, 4'b0000, 6'd0);

    // sparse requests and pointer wrap (ptr 0 -> 3 -> 1 -> 3 -> 1 -> 1)
    set_req(2, OP_SUB, 6'd10, 6'd4);  cycle(4'b0100, 4'b0100, 6'd6);
    set_req(0, OP_ADD, 6'd20, 6'd30); cycle(4'b0101, 4'b0001, 6'd50);
    set_req(2, OP_SUB, 6'd0, 6'd1);   cycle(4'b0101, 4'b0100, 6'd63);
    set_req(0, OP_NOP, 6'd7, 6'd9);   cycle(4'b0001, 4'b0001, 6'd0);
    set_req(0, OP_ADD, 6'd31, 6'd31); cycle(4'b0001, 4'b0001, 6'd62);
    repeat (3) cycle(4'b0000, 4'b0000, 6'd0);

    // reset mid-flight drops the in-flight result and rewinds the pointer
    set_req(1, OP_ADD, 6'd1, 6'd1);   cycle(4'b0010, 4'b0010, 6'd2);
    rst = 1'b1;
    exp_q.delete();
    cycle(4'b0100, 4'b0000, 6'd0);
    rst = 1'b0;
    idle_quiet();
    idle_quiet();
    for (int i = 0; i < N; i++) set_req(i, OP_ADD, 6'(i + 1), 6'd10);
    cycle(4'hF, 4'b0001, 6'd11);
    repeat (3) cycle(4'b0000, 4'b0000, 6'd0);

    // spurious ALU valid with an empty tag pipeline
    chk("err_before_mismatch", 32'(err), 32'h0);
    force_ov = 1'b1;
    @(negedge clk);
    chk("mismatch_resp", 32'(bus.resp_valid), 32'h0);
    @(posedge clk); #1;
    force_ov = 1'b0;
    chk("err_set", 32'(err), 32'h1);
    repeat (3) cycle(4'b0000, 4'b0000, 6'd0);
    chk("err_sticky", 32'(err), 32'h1);

`ifdef ALU_ARB_STATS_EN
    rst = 1'b1; cycle(4'b0000, 4'b0000, 6'd0); rst = 1'b0;
    chk("err_cleared", 32'(err), 32'h0);
    set_req(0, OP_NOP, 6'd0, 6'd0);
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      exp_q.push_back({4'b0001, 6'd0});
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    chk("grant_cnt0_sat", 32'(grant_cnt[15:0]), 32'hFFFF);
    chk("grant_cnt1", 32'(grant_cnt[31:16]), 32'h0);
    chk("busy_cnt_sat", 32'(busy_cnt), 32'hFFFF);
`endif

    repeat (3) cycle(4'b0000, 4'b0000, 6'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
